fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline; directly upstream of the decode/frontend-recovery logic.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Predecodes each fetched word with static prediction: conditional branches taken, `j`/`jal` direct, everything else PC+4.
- Accepts `miss`/`rpc` from the frontend recovery logic to flush wrong-path work and redirect. Delivers `{valid, instr, pc}` to decode through a 1-entry skid buffer under stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  response valid this cycle for current imem_addr
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ready
- stall  in  1  decode cannot accept; hold id_* outputs
- miss  in  1  misprediction / jr redirect
- rpc  in  32  redirect target, valid when miss=1
- id_valid  out  1  id_instr/id_pc hold a live instruction
- id_instr  out  32  fetched instruction
- id_pc  out  32  address of id_instr

Behaviour:
- Reset (asynchronous, resetn=0):
  - pc=RESET_PC, state=S_FETCH.
  - id_valid=0, id_instr=0, id_pc=0.
  - skid empty, redirect register cleared.
  - imem_req=0 while resetn=0; first request in the first cycle after release.
- Reset asserted mid-request aborts it; the response is ignored.
- FSM states:
  - S_FETCH:
    - imem_req=1 when skid empty, else 0.
    - imem_addr=pc.
    - Address is held stable while imem_req && !imem_ready.
  - S_DROP: request outstanding, but its result is wrong-path.
    - imem_req stays 1 at the old address until imem_ready.
    - Response is discarded.
    - pc<=redir_pc and state<=S_FETCH.
- Accept (S_FETCH, imem_req && imem_ready && !miss):
  - Word goes to the output register when (!id_valid || !stall); otherwise it goes to skid.
  - pc<=next_pc(word, pc).
- next_pc:
  - beq (000100) / bne (000101): pc+4+(sext(imm16)<<2), 32-bit wrap.
  - j (000010) / jal (000011): {pc_plus4[31:28], instr[25:0], 2'b00}.
  - All others, including jr: pc+4.
- Output register:
  - When !stall: loads the skid entry if skid full (skid empties), else a same-cycle accepted word, else id_valid<=0.
  - When stall: id_* hold.
- Latency: request accepted in cycle N appears on id_* in cycle N+1.
- miss=1 (highest priority, overrides stall):
  - id_valid<=0 and skid cleared.
  - Any same-cycle imem response is discarded.
  - If imem_req && !imem_ready (request in flight): state<=S_DROP, redir_pc<=rpc.
  - Else: pc<=rpc, stay S_FETCH.
  - miss while already in S_DROP: redir_pc updated to the newest rpc.
- Skid full and stall=1: no new request issued. Throughput is 1 instr/cycle when imem_ready is always 1 and stall=0.
- rpc is used as-is; a misaligned rpc is a caller error, and low bits are forced to 00 on imem_addr.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs `perf_fetched` (32), `perf_redirects` (32), `perf_drops` (32).
  - Counters reset to 0 and wrap.
  - `perf_fetched` increments per accepted non-discarded word.
  - `perf_redirects` increments per cycle with miss=1.
  - `perf_drops` increments per discarded response.
- FETCH_PERF_EN undefined: no ports, no counter logic.

Decomposition:
- Shared package pipeline_pkg holds:
  - Opcode constants OP_SPECIAL, OP_BEQ, OP_BNE, OP_J, OP_JAL and FUNCT_JR.
  - State enum fetch_state_t {S_FETCH, S_DROP}.
  - Struct fetch_pkt_t {valid, instr, pc}, used for both the output register and the skid.
- One sub-module, fetch_predecode: combinational, takes (instr, pc) and returns next_pc. Reused by the verification model.

Test Plan:
- Sequential flow: RESET_PC=0, imem_ready=1, memory of 4 nops, stall=0 → id_pc 0,4,8,C on consecutive cycles after release, id_valid=1 from the second cycle.
- beq predicted taken: beq at 0x10 with imm=0x0003 → next request address 0x20. Then miss=1, rpc=0x14 → id_valid=0 next cycle, imem_addr=0x14.
- j direct: j at 0x3000_0040 with target=0x0000100 → next imem_addr 0x3000_0400.
- Stall/skid: stall=1 for 3 cycles while fetching 0x0,0x4 → id holds 0x0, skid holds 0x4, imem_req=0 during stall. Release → id 0x4 then 0x8, nothing lost or duplicated.
- Drop: imem_ready=0 for 2 cycles at 0x8, miss=1 with rpc=0x100 in the first wait cycle → imem_addr stays 0x8 until ready, response discarded, next request 0x100, id_valid stays 0 throughout.
- Async reset: resetn=0 mid-wait at 0x24 → id_valid=0, imem_req=0 immediately. After release, first request at RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MIPS opcode constants, fetch FSM states and
// the fetch packet carried by the output register and the skid buffer.
package pipeline_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DROP  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_pkt_t;

    localparam fetch_pkt_t PKT_EMPTY = '{valid: 1'b0, instr: 32'h0, pc: 32'h0};

endpackage

// File: rtl/fetch_predecode.sv
// Static next-PC prediction: conditional branches taken, j/jal direct,
// everything else (jr included) falls through to pc+4.
module fetch_predecode
    import pipeline_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic [31:0] next_pc
);

    logic [5:0]  opcode;
    logic [31:0] pc_plus4;
    logic [31:0] br_offset;

    assign opcode    = instr[31:26];
    assign pc_plus4  = pc + 32'd4;
    assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (opcode)
            OP_BEQ, OP_BNE: next_pc = pc_plus4 + br_offset;
            OP_J, OP_JAL:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            // jr targets are unknown here; decode corrects them through miss/rpc
            OP_SPECIAL:     next_pc = pc_plus4;
            default:        next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem request, static
// prediction, miss redirect and a 1-entry skid. FETCH_PERF_EN adds counters.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        miss,
    input  logic [31:0] rpc,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_drops,
`endif
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  redir_pc_reg, redir_pc_next;
    fetch_pkt_t   out_reg, out_next;
    fetch_pkt_t   skid_reg, skid_next;
    fetch_pkt_t   fetched_pkt;
    logic [31:0]  pred_pc;
    logic         req;
    logic         resp;
    logic         accept;

    fetch_predecode u_predecode (
        .instr   (imem_rdata),
        .pc      (pc_reg),
        .next_pc (pred_pc)
    );

    // An in-flight wrong-path request must still complete, so S_DROP requests even with a full skid
    assign req         = resetn && ((state_reg == S_DROP) || !skid_reg.valid);
    assign resp        = req && imem_ready;
    assign accept      = resp && (state_reg == S_FETCH) && !miss;
    assign fetched_pkt = '{valid: 1'b1, instr: imem_rdata, pc: pc_reg};

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        redir_pc_next = redir_pc_reg;
        out_next      = out_reg;
        skid_next     = skid_reg;
        if (miss) begin
            out_next.valid  = 1'b0;
            skid_next.valid = 1'b0;
            if (req && !imem_ready) begin
                state_next    = S_DROP;
                redir_pc_next = rpc;
            end else begin
                state_next = S_FETCH;
                pc_next    = rpc;
            end
        end else begin
            if (resp && (state_reg == S_DROP)) begin
                state_next = S_FETCH;
                pc_next    = redir_pc_reg;
            end
            if (accept) begin
                pc_next = pred_pc;
            end
            if (!stall) begin
                if (skid_reg.valid) begin
                    out_next        = skid_reg;
                    skid_next.valid = 1'b0;
                end else if (accept) begin
                    out_next = fetched_pkt;
                end else begin
                    out_next.valid = 1'b0;
                end
            end else if (accept) begin
                if (!out_reg.valid) begin
                    out_next = fetched_pkt;
                end else begin
                    skid_next = fetched_pkt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_FETCH;
            pc_reg       <= RESET_PC;
            redir_pc_reg <= 32'h0;
            out_reg      <= PKT_EMPTY;
            skid_reg     <= PKT_EMPTY;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            redir_pc_reg <= redir_pc_next;
            out_reg      <= out_next;
            skid_reg     <= skid_next;
        end
    end

    assign imem_req  = req;
    assign imem_addr = {pc_reg[31:2], 2'b00};
    assign id_valid  = out_reg.valid;
    assign id_instr  = out_reg.instr;
    assign id_pc     = out_reg.pc;

`ifdef FETCH_PERF_EN
    logic [2:0] perf_inc;

    // bit 0: accepted words, bit 1: redirect cycles, bit 2: discarded responses
    assign perf_inc = {resp && (miss || (state_reg == S_DROP)), miss, accept};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    cnt_reg <= 32'h0;
                end else if (perf_inc[gi]) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_fetched   = g_perf[0].cnt_reg;
    assign perf_redirects = g_perf[1].cnt_reg;
    assign perf_drops     = g_perf[2].cnt_reg;
`endif

endmodule
